// File: rtl/cache_pkg.sv
// Shared types and tree pseudo-LRU helpers for the set-associative cache controller.
// The tree is heap-ordered: node 0 is the root and a node bit of 1 means the victim is in the upper half.
package cache_pkg;

    typedef enum logic [1:0] {
        COMPARE,
        DELAY,
        WRITE_BACK,
        ALLOCATE
    } cache_state_t;

    localparam int DEFAULT_WAYS     = 4;
    localparam int DEFAULT_IDX_LO   = 5;
    localparam int DEFAULT_IDX_BITS = 4;

    localparam int MAX_WAYS  = 8;
    localparam int MAX_NODES = MAX_WAYS - 1;

    // Walk from the root, following each node bit toward the least recently used half.
    function automatic logic [2:0] plru_victim(input logic [MAX_NODES-1:0] bits,
                                               input int ways);
        logic [2:0] way;
        logic       dir;
        int         node;
        way  = '0;
        node = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            if ((1 << lvl) < ways) begin
                dir  = bits[node[2:0]];
                way  = {way[1:0], dir};
                node = 2 * node + 1 + (dir ? 1 : 0);
            end
        end
        return way;
    endfunction

    // Point every node on the path to 'way' away from it.
    function automatic logic [MAX_NODES-1:0] plru_update(input logic [MAX_NODES-1:0] bits,
                                                         input logic [2:0] way,
                                                         input int ways);
        logic [MAX_NODES-1:0] res;
        logic                 dir;
        int                   node;
        int                   levels;
        res    = bits;
        node   = 0;
        levels = 0;
        for (int lvl = 0; lvl < 3; lvl++) begin
            if ((1 << lvl) < ways) begin
                levels++;
            end
        end
        for (int lvl = 0; lvl < 3; lvl++) begin
            if (lvl < levels) begin
                dir              = way[2'(levels - 1 - lvl)];
                res[node[2:0]]   = ~dir;
                node             = 2 * node + 1 + (dir ? 1 : 0);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/plru_array.sv
// Per-set tree pseudo-LRU state: one WAYS-1 bit tree per set, cleared by reset.
module plru_array
    import cache_pkg::*;
#(
    parameter int WAYS     = DEFAULT_WAYS,
    parameter int IDX_BITS = DEFAULT_IDX_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IDX_BITS-1:0]       rd_index,
    output logic [WAYS-2:0]           rd_bits,
    input  logic                      upd_en,
    input  logic [IDX_BITS-1:0]       upd_index,
    input  logic [$clog2(WAYS)-1:0]   upd_way
);

    localparam int SETS  = 2 ** IDX_BITS;
    localparam int NODES = WAYS - 1;

    logic [NODES-1:0] tree [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                tree[s] <= '0;
            end
        end else if (upd_en) begin
            tree[upd_index] <= NODES'(plru_update(MAX_NODES'(tree[upd_index]), 3'(upd_way), WAYS));
        end
    end

    assign rd_bits = tree[rd_index];

endmodule

// File: rtl/cache_control_assoc.sv
// Write-back, write-allocate control FSM for an N-way set-associative cache with
// per-set tree pseudo-LRU replacement; the tag/data/valid/dirty arrays live in the datapath.
module cache_control_assoc
    import cache_pkg::*;
#(
    parameter int WAYS     = DEFAULT_WAYS,
    parameter int IDX_LO   = DEFAULT_IDX_LO,
    parameter int IDX_BITS = DEFAULT_IDX_BITS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             mem_address,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [WAYS-1:0]         hit_vec,
    input  logic [WAYS-1:0]         valid_vec,
    input  logic [WAYS-1:0]         dirty_vec,
    input  logic                    pmem_resp,
    output logic                    pmem_read,
    output logic                    pmem_write,
    output logic                    mem_resp,
    output logic                    data_mux,
    output logic                    writetomem,
    output logic                    write_masked,
    output logic                    index_change,
    output logic [$clog2(WAYS)-1:0] way_sel
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int SETS  = 2 ** IDX_BITS;

    cache_state_t        state, next_state;
    logic [IDX_BITS-1:0] index, index_prev;
    logic [WAY_W-1:0]    hit_way, free_way, victim, victim_q;
    logic [WAYS-2:0]     plru_bits;
    logic                req, hit, all_valid, load_victim;
    logic [31:0]         addr_unused;

    assign index        = mem_address[IDX_LO +: IDX_BITS];
    assign addr_unused  = mem_address & ~(32'(SETS - 1) << IDX_LO);
    assign index_change = (index != index_prev);
    assign req          = mem_read | mem_write;
    assign hit          = |hit_vec;
    assign all_valid    = &valid_vec;

    // Lowest-index matching way and lowest-index empty way.
    always_comb begin
        hit_way  = '0;
        free_way = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_way = WAY_W'(i);
            end
            if (!valid_vec[i]) begin
                free_way = WAY_W'(i);
            end
        end
    end

    // Empty ways are always filled first; the PLRU tree only decides among full sets.
    always_comb begin
        victim = free_way;
        if (all_valid) begin
            victim = WAY_W'(plru_victim(MAX_NODES'(plru_bits), WAYS));
        end
    end

    plru_array #(
        .WAYS     (WAYS),
        .IDX_BITS (IDX_BITS)
    ) u_plru (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (index),
        .rd_bits   (plru_bits),
        .upd_en    (mem_resp),
        .upd_index (index),
        .upd_way   (hit_way)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= COMPARE;
            index_prev <= '0;
            victim_q   <= '0;
        end else begin
            state      <= next_state;
            index_prev <= index;
            if (load_victim) begin
                victim_q <= victim;
            end
        end
    end

    // After an index change the arrays are read for one bubble cycle before the tag result is trusted.
    always_comb begin
        next_state   = state;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        data_mux     = 1'b0;
        writetomem   = 1'b0;
        write_masked = 1'b0;
        way_sel      = '0;
        load_victim  = 1'b0;
        case (state)
            COMPARE: begin
                write_masked = ~index_change;
                if (req) begin
                    if (index_change) begin
                        next_state = DELAY;
                    end else if (hit) begin
                        mem_resp = 1'b1;
                        way_sel  = hit_way;
                    end else begin
                        load_victim = 1'b1;
                        next_state  = dirty_vec[victim] ? WRITE_BACK : ALLOCATE;
                    end
                end
            end
            DELAY: begin
                write_masked = 1'b1;
                if (hit) begin
                    mem_resp   = 1'b1;
                    way_sel    = hit_way;
                    next_state = COMPARE;
                end else if (req) begin
                    load_victim = 1'b1;
                    next_state  = dirty_vec[victim] ? WRITE_BACK : ALLOCATE;
                end else begin
                    next_state = COMPARE;
                end
            end
            WRITE_BACK: begin
                pmem_write = 1'b1;
                writetomem = 1'b1;
                way_sel    = victim_q;
                if (pmem_resp) begin
                    next_state = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read = 1'b1;
                data_mux  = 1'b1;
                way_sel   = victim_q;
                if (pmem_resp) begin
                    next_state = COMPARE;
                end
            end
            default: begin
                next_state = COMPARE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_control_assoc.sv
// Bench for cache_control_assoc: directed scenarios with literal expectations plus randomized
// traffic, all checked each cycle against a timestamp-based replacement model.
module tb_cache_control_assoc;

    localparam int WAYS     = 4;
    localparam int IDX_LO   = 5;
    localparam int IDX_BITS = 4;
    localparam int SETS     = 16;

    localparam int P_CMP = 0;
    localparam int P_BUB = 1;
    localparam int P_WB  = 2;
    localparam int P_RF  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_address = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [3:0]  hit_vec = '0;
    logic [3:0]  valid_vec = '0;
    logic [3:0]  dirty_vec = '0;
    logic        pmem_resp = 1'b0;
    logic        pmem_read, pmem_write, mem_resp, data_mux, writetomem, write_masked, index_change;
    logic [1:0]  way_sel;

    int compared   = 0;
    int mismatched = 0;

    // Model state: phase of the current request, latched victim, last index and per-way access times.
    int m_phase = P_CMP;
    int m_vq    = 0;
    int m_prev  = 0;
    int stamp   = 0;
    int ts [SETS][WAYS];

    int got_victim [4];
    int want_victim [4];

    always #5 clk = ~clk;

    cache_control_assoc #(
        .WAYS     (WAYS),
        .IDX_LO   (IDX_LO),
        .IDX_BITS (IDX_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_address  (mem_address),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .hit_vec      (hit_vec),
        .valid_vec    (valid_vec),
        .dirty_vec    (dirty_vec),
        .pmem_resp    (pmem_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .mem_resp     (mem_resp),
        .data_mux     (data_mux),
        .writetomem   (writetomem),
        .write_masked (write_masked),
        .index_change (index_change),
        .way_sel      (way_sel)
    );

    // Tree PLRU seen as recency: at each split, the half holding the most recently used way is
    // protected, so descend into the other half; untouched subtrees default to the lower half.
    function automatic int model_victim(input int set, input logic [3:0] vv);
        int lo, size, half, ml, mr;
        for (int i = 0; i < WAYS; i++) begin
            if (!vv[i]) return i;
        end
        lo   = 0;
        size = WAYS;
        while (size > 1) begin
            half = size / 2;
            ml   = 0;
            mr   = 0;
            for (int i = 0; i < half; i++) begin
                if (ts[set][lo + i] > ml) ml = ts[set][lo + i];
                if (ts[set][lo + half + i] > mr) mr = ts[set][lo + half + i];
            end
            if (ml > mr) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin : compare_proc
        int          idx, hw, vic, nxt;
        logic        req, hit, load;
        logic        e_pr, e_pw, e_resp, e_dm, e_wtm, e_wm, e_ic;
        int          e_ws;
        logic [8:0]  exp_v, act_v;
        if (rst) begin
            m_phase = P_CMP;
            m_vq    = 0;
            m_prev  = 0;
            stamp   = 0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    ts[s][w] = 0;
        end
        idx  = int'(mem_address[IDX_LO +: IDX_BITS]);
        req  = mem_read | mem_write;
        hit  = |hit_vec;
        hw   = 0;
        for (int i = WAYS - 1; i >= 0; i--) if (hit_vec[i]) hw = i;
        vic  = model_victim(idx, valid_vec);
        e_ic = (idx != m_prev);
        {e_pr, e_pw, e_resp, e_dm, e_wtm, e_wm} = '0;
        e_ws = 0;
        load = 1'b0;
        nxt  = m_phase;
        case (m_phase)
            P_CMP: begin
                e_wm = !e_ic;
                if (req && e_ic) nxt = P_BUB;
                else if (req && hit) begin e_resp = 1; e_ws = hw; end
                else if (req) begin load = 1; nxt = dirty_vec[vic] ? P_WB : P_RF; end
            end
            P_BUB: begin
                e_wm = 1;
                if (hit) begin e_resp = 1; e_ws = hw; nxt = P_CMP; end
                else if (req) begin load = 1; nxt = dirty_vec[vic] ? P_WB : P_RF; end
                else nxt = P_CMP;
            end
            P_WB: begin
                e_pw = 1; e_wtm = 1; e_ws = m_vq;
                if (pmem_resp) nxt = P_RF;
            end
            default: begin
                e_pr = 1; e_dm = 1; e_ws = m_vq;
                if (pmem_resp) nxt = P_CMP;
            end
        endcase
        exp_v = {e_pr, e_pw, e_resp, e_dm, e_wtm, e_wm, e_ic, 2'(e_ws)};
        act_v = {pmem_read, pmem_write, mem_resp, data_mux, writetomem, write_masked, index_change, way_sel};
        compared++;
        if (act_v !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL cycle_compare: actual=%b expected=%b (rd,wr,resp,mux,wtm,wm,ic,way) at t=%0t",
                     act_v, exp_v, $time);
        end
        if (!rst) begin
            if (e_resp) begin
                stamp++;
                ts[idx][hw] = stamp;
            end
            if (load) m_vq = vic;
            m_phase = nxt;
            m_prev  = idx;
        end
    end

    task automatic apply_stimulus(input int idx, input logic rd, input logic wr, input logic [3:0] hv,
                                  input logic [3:0] vv, input logic [3:0] dv, input logic pr);
        @(posedge clk);
        #1;
        mem_address = ($urandom & 32'hFFFF_FE1F) | (32'(idx) << IDX_LO);
        mem_read    = rd;
        mem_write   = wr;
        hit_vec     = hv;
        valid_vec   = vv;
        dirty_vec   = dv;
        pmem_resp   = pr;
        @(negedge clk);
        #1;
    endtask

    initial begin
        want_victim[0] = 0;
        want_victim[1] = 2;
        want_victim[2] = 1;
        want_victim[3] = 3;

        @(negedge clk);
        #1;
        check_output("reset_mem_resp", 32'(mem_resp), 0);
        check_output("reset_pmem_read", 32'(pmem_read), 0);
        check_output("reset_way_sel", 32'(way_sel), 0);
        check_output("reset_write_masked", 32'(write_masked), 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Set 3: index settles, then a hit on way 2 steers the next victim away from it.
        apply_stimulus(3, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        check_output("idx_change_flag", 32'(index_change), 1);
        check_output("idx_change_wm", 32'(write_masked), 0);
        apply_stimulus(3, 1, 0, 4'b0100, 4'b1111, 4'b0000, 0);
        check_output("hit_resp", 32'(mem_resp), 1);
        check_output("hit_way_sel", 32'(way_sel), 2);
        apply_stimulus(3, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        check_output("miss_no_resp", 32'(mem_resp), 0);
        apply_stimulus(3, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        check_output("alloc_pmem_read", 32'(pmem_read), 1);
        check_output("alloc_data_mux", 32'(data_mux), 1);
        check_output("plru_avoids_way2", 32'(way_sel), 0);
        apply_stimulus(3, 1, 0, 4'b0000, 4'b1111, 4'b0000, 1);
        apply_stimulus(3, 1, 0, 4'b0001, 4'b1111, 4'b0000, 0);
        check_output("refill_then_hit", 32'(mem_resp), 1);
        check_output("pmem_read_dropped", 32'(pmem_read), 0);

        // Reset in the middle of a refill.
        apply_stimulus(3, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        apply_stimulus(3, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        check_output("second_victim", 32'(way_sel), 3);
        check_output("second_alloc", 32'(pmem_read), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        mem_read = 1'b0;
        mem_address = '0;
        hit_vec = '0;
        #1;
        check_output("async_reset_pmem_read", 32'(pmem_read), 0);
        check_output("async_reset_data_mux", 32'(data_mux), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        apply_stimulus(3, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        apply_stimulus(3, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        apply_stimulus(3, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        check_output("reset_cleared_plru", 32'(way_sel), 0);
        apply_stimulus(3, 1, 0, 4'b0000, 4'b1111, 4'b0000, 1);
        apply_stimulus(3, 1, 0, 4'b0001, 4'b1111, 4'b0000, 0);
        check_output("post_reset_hit", 32'(mem_resp), 1);

        // Index change 3 -> 5 with a hit costs one bubble.
        apply_stimulus(5, 1, 0, 4'b0001, 4'b1111, 4'b0000, 0);
        check_output("ic_bubble", 32'(mem_resp), 0);
        apply_stimulus(5, 1, 0, 4'b0001, 4'b1111, 4'b0000, 0);
        check_output("ic_resp", 32'(mem_resp), 1);
        check_output("ic_resp_wm", 32'(write_masked), 1);

        // Dirty miss: four write-back cycles then four refill cycles into way 2.
        apply_stimulus(5, 1, 0, 4'b0000, 4'b1111, 4'b1111, 0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(5, 1, 0, 4'b0000, 4'b1111, 4'b1111, logic'(i == 3));
            check_output("wb_pmem_write", 32'(pmem_write), 1);
            check_output("wb_way_sel", 32'(way_sel), 2);
        end
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(5, 1, 0, 4'b0000, 4'b1111, 4'b1111, logic'(i == 3));
            check_output("wb_alloc_read", 32'(pmem_read), 1);
            check_output("wb_alloc_way_sel", 32'(way_sel), 2);
        end
        apply_stimulus(5, 1, 0, 4'b0100, 4'b1111, 4'b1111, 0);
        check_output("dirty_miss_resp", 32'(mem_resp), 1);

        // An invalid way is filled before any PLRU choice, with no write-back.
        apply_stimulus(5, 0, 1, 4'b0000, 4'b1011, 4'b1011, 0);
        apply_stimulus(5, 0, 1, 4'b0000, 4'b1011, 4'b1011, 0);
        check_output("invalid_way_first", 32'(way_sel), 2);
        check_output("invalid_no_wb", 32'(pmem_write), 0);
        apply_stimulus(5, 0, 1, 4'b0000, 4'b1011, 4'b1011, 1);
        apply_stimulus(5, 0, 1, 4'b0100, 4'b1111, 4'b1111, 0);
        check_output("invalid_fill_resp", 32'(mem_resp), 1);

        // Four misses to a fresh set cycle through every way.
        apply_stimulus(7, 0, 0, 4'b0000, 4'b1111, 4'b0000, 0);
        for (int k = 0; k < 4; k++) begin
            apply_stimulus(7, 1, 0, 4'b0000, 4'b1111, 4'b0000, 0);
            apply_stimulus(7, 1, 0, 4'b0000, 4'b1111, 4'b0000, 1);
            got_victim[k] = int'(way_sel);
            apply_stimulus(7, 1, 0, 4'(1 << m_vq), 4'b1111, 4'b0000, 0);
            check_output("cycle_hit_resp", 32'(mem_resp), 1);
        end
        for (int k = 0; k < 4; k++) begin
            check_output("plru_cycle_victim", 32'(got_victim[k]), 32'(want_victim[k]));
        end

        // Randomized traffic, including occasional resets.
        begin
            int idx;
            logic rd, wr, pr;
            logic [3:0] hv, vv, dv;
            idx = 0;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(4) == 0) idx = int'($urandom_range(SETS - 1));
                case ($urandom_range(3))
                    0: begin rd = 0; wr = 0; end
                    1: begin rd = 1; wr = 0; end
                    2: begin rd = 0; wr = 1; end
                    default: begin rd = 1; wr = 1; end
                endcase
                case ($urandom_range(9))
                    0, 1, 2, 3, 4: hv = 4'b0000;
                    9:             hv = 4'($urandom);
                    default:       hv = 4'(1 << $urandom_range(3));
                endcase
                vv = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b1111;
                dv = 4'($urandom);
                pr = ($urandom_range(2) == 0);
                if ($urandom_range(150) == 0) begin
                    @(posedge clk);
                    #1;
                    rst = 1'b1;
                    mem_read = 1'b0;
                    mem_write = 1'b0;
                    @(posedge clk);
                    #1 rst = 1'b0;
                end
                apply_stimulus(idx, rd, wr, hv, vv, dv, pr);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
